// File: rtl/uart_hex_tx_if.sv
// Producer/UART-side bundle for uart_hex_tx: print request, status and the
// per-byte transmit handshake toward the UART core.
interface uart_hex_tx_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  start;
    logic [DATA_WIDTH-1:0] data;
    logic                  busy;
    logic                  done;
    logic                  tx_start;
    logic [7:0]            tx_data;
    logic                  tx_busy;

    // Environment side: producer plus UART transmitter.
    modport master (
        output start, data, tx_busy,
        input  busy, done, tx_start, tx_data
    );

    // Formatter side.
    modport slave (
        input  start, data, tx_busy,
        output busy, done, tx_start, tx_data
    );
endinterface

// File: rtl/uart_hex_tx.sv
// Prints a DATA_WIDTH-bit word as ASCII hex (MSB nibble first, optional CR LF)
// by feeding bytes one at a time into the UART transmit handshake.
module uart_hex_tx #(
    parameter int DATA_WIDTH = 16,
    parameter bit SEND_CRLF  = 1'b1,
    parameter bit UPPERCASE  = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    uart_hex_tx_if.slave bus,
    output logic [1:0]   state_o
);
    localparam int NDIG   = DATA_WIDTH / 4;
    localparam int NBYTES = NDIG + (SEND_CRLF ? 2 : 0);
    localparam int CW     = $clog2(NBYTES + 1);

    typedef enum logic [1:0] {IDLE, WAIT_IDLE, REQ, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'd0, n};
        return (UPPERCASE ? 8'h41 : 8'h61) + {4'd0, n} - 8'd10;
    endfunction

    // UART handshake: tx_start is held high with tx_data stable until tx_busy
    // is sampled high (byte taken); the next byte is only offered after
    // tx_busy has been sampled low again.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shift_d   = bus.data;
                    cnt_d     = CW'(NBYTES);
                    tx_data_d = hex_char(bus.data[DATA_WIDTH-1 -: 4]);
                    state_d   = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (!bus.tx_busy) state_d = REQ;
            end
            REQ: begin
                if (bus.tx_busy) state_d = DRAIN;
            end
            DRAIN: begin
                if (!bus.tx_busy) begin
                    if (cnt_q == CW'(1)) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // cnt_d counts bytes still to send, so the last two are CR/LF.
                        cnt_d   = cnt_q - CW'(1);
                        shift_d = shift_q << 4;
                        state_d = REQ;
                        if (SEND_CRLF && cnt_d == CW'(2))
                            tx_data_d = 8'h0D;
                        else if (SEND_CRLF && cnt_d == CW'(1))
                            tx_data_d = 8'h0A;
                        else
                            tx_data_d = hex_char(shift_d[DATA_WIDTH-1 -: 4]);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            tx_data_q <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.tx_start = (state_q == REQ);
    assign bus.tx_data  = tx_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign state_o      = state_q;
endmodule
